l1_mem_responder: RTL and testbench

L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

---
 rtl/l1_mem_responder_pkg.sv | 27 ++
 rtl/l1_burst_counter.sv | 47 ++++
 rtl/l1_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_l1_mem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_responder_pkg.sv
// Shared types for the L1 memory responder: FSM states, AMO opcodes, burst helpers.
package l1_mem_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StSc,
        StInv
    } state_e;

    localparam int unsigned SizeW = 5;

    localparam logic [SizeW-1:0] AmoLr = 5'b00010;
    localparam logic [SizeW-1:0] AmoSc = 5'b00011;

    // Word-offset mask of the smallest power-of-two window that holds idx+1 words.
    function automatic logic [SizeW-1:0] burst_mask(input logic [SizeW-1:0] idx);
        logic [SizeW-1:0] m;
        m = idx;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/l1_burst_counter.sv
// Burst address generator: walks base..base+last_idx, one word per cycle after start.
module l1_burst_counter
    import l1_mem_responder_pkg::*;
#(
    parameter int unsigned AddrW = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AddrW-1:0] base,
    input  logic [SizeW-1:0] last_idx,
    output logic             active,
    output logic             last,
    output logic [AddrW-1:0] addr
);

    logic             active_q;
    logic [SizeW-1:0] cnt_q;
    logic [SizeW-1:0] last_idx_q;
    logic [AddrW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            addr_q     <= '0;
        end else if (start) begin
            active_q   <= 1'b1;
            cnt_q      <= '0;
            last_idx_q <= last_idx;
            addr_q     <= base;
        end else if (active_q) begin
            if (cnt_q == last_idx_q) begin
                active_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + SizeW'(1);
                addr_q <= addr_q + AddrW'(1);
            end
        end
    end

    assign active = active_q;
    assign last   = active_q && (cnt_q == last_idx_q);
    assign addr   = addr_q;

endmodule

// File: rtl/l1_mem_responder.sv
// L1 arbiter request responder: burst reads, writes, LR/SC reservation and snoop invalidates
// against a single-port RAM with one-cycle read latency.
module l1_mem_responder
    import l1_mem_responder_pkg::*;
#(
    parameter int unsigned LINE_W     = 4,
    parameter int unsigned MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    // Cache request
    input  logic                  req_request,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_data,
    input  logic                  req_rnw,
    input  logic [3:0]            req_be,
    input  logic [4:0]            req_size,
    input  logic                  req_is_amo,
    input  logic [4:0]            req_amo,
    output logic                  req_ack,
    // Responses
    output logic [31:0]           rsp_data,
    output logic                  rsp_data_valid,
    output logic [29:0]           rsp_inv_addr,
    output logic                  rsp_inv_valid,
    input  logic                  rsp_inv_ack,
    output logic                  sc_complete,
    output logic                  sc_success,
    // Foreign-master write notification
    input  logic                  ext_wr_valid,
    input  logic [31:0]           ext_wr_addr,
    output logic                  ext_wr_ready,
    // Backing RAM
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [SizeW-1:0] MaxIdx = SizeW'(LINE_W - 1);

    state_e state_q, state_d;

    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [29:0] inv_addr_q;
    logic        resv_valid_q, resv_valid_d;
    logic [29:0] resv_addr_q, resv_addr_d;
    logic        rd_pending_q;

    logic [SizeW-1:0]      size_idx;
    logic [29:0]           word_base;
    logic                  is_lr;
    logic                  is_sc;
    logic                  sc_match;
    logic                  burst_start;
    logic                  burst_active;
    logic                  burst_last;
    logic [MEM_ADDR_W-1:0] burst_addr;
    logic                  unused_bits;

    assign size_idx  = (req_size > MaxIdx) ? MaxIdx : req_size;
    assign word_base = req_addr[31:2] & ~{25'b0, burst_mask(size_idx)};
    assign is_lr     = req_is_amo && (req_amo == AmoLr);
    assign is_sc     = req_is_amo && (req_amo == AmoSc) && !req_rnw;
    assign sc_match  = resv_valid_q && (resv_addr_q == addr_q);

    assign unused_bits = ^{req_addr[1:0], ext_wr_addr[1:0], word_base, burst_last};

    l1_burst_counter #(
        .AddrW (MEM_ADDR_W)
    ) u_burst_counter (
        .clk      (clk),
        .rst      (rst),
        .start    (burst_start),
        .base     (word_base[MEM_ADDR_W-1:0]),
        .last_idx (size_idx),
        .active   (burst_active),
        .last     (burst_last),
        .addr     (burst_addr)
    );

    always_comb begin
        state_d       = state_q;
        req_ack       = 1'b0;
        burst_start   = 1'b0;
        rsp_inv_valid = 1'b0;
        rsp_inv_addr  = '0;
        ext_wr_ready  = 1'b0;
        sc_complete   = 1'b0;
        sc_success    = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_be        = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        resv_valid_d  = resv_valid_q;
        resv_addr_d   = resv_addr_q;

        unique case (state_q)
            StIdle: begin
                // A pending snoop always wins over the cache request.
                if (ext_wr_valid) begin
                    state_d = StInv;
                end else if (req_request) begin
                    req_ack = 1'b1;
                    if (is_sc) begin
                        state_d = StSc;
                    end else if (req_is_amo || req_rnw) begin
                        state_d     = StRead;
                        burst_start = 1'b1;
                        if (is_lr) begin
                            resv_valid_d = 1'b1;
                            resv_addr_d  = req_addr[31:2];
                        end
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                mem_en   = burst_active;
                mem_addr = burst_addr;
                // Stay one cycle past the last issue so the final word returns here.
                if (!burst_active) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = be_q;
                mem_addr  = addr_q[MEM_ADDR_W-1:0];
                mem_wdata = data_q;
                if (resv_addr_q == addr_q) begin
                    resv_valid_d = 1'b0;
                end
                state_d = StIdle;
            end
            StSc: begin
                sc_complete  = 1'b1;
                sc_success   = sc_match;
                resv_valid_d = 1'b0;
                if (sc_match) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_be    = be_q;
                    mem_addr  = addr_q[MEM_ADDR_W-1:0];
                    mem_wdata = data_q;
                end
                state_d = StIdle;
            end
            StInv: begin
                rsp_inv_valid = 1'b1;
                rsp_inv_addr  = inv_addr_q;
                if (rsp_inv_ack) begin
                    ext_wr_ready = 1'b1;
                    if (resv_addr_q == inv_addr_q) begin
                        resv_valid_d = 1'b0;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
            inv_addr_q   <= '0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            rd_pending_q <= (state_q == StRead) && burst_active;
            if (req_ack) begin
                addr_q <= req_addr[31:2];
                data_q <= req_data;
                be_q   <= req_be;
            end
            if ((state_q == StIdle) && ext_wr_valid) begin
                inv_addr_q <= ext_wr_addr[31:2];
            end
        end
    end

    assign rsp_data_valid = rd_pending_q;
    assign rsp_data       = rd_pending_q ? mem_rdata : '0;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder with a RAM model and queue-based scoreboard.
module tb_l1_mem_responder;

    localparam int unsigned MemAw    = 14;
    localparam int unsigned MemWords = 1 << MemAw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_request;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_rnw;
    logic [3:0]  req_be;
    logic [4:0]  req_size;
    logic        req_is_amo;
    logic [4:0]  req_amo;
    logic        req_ack;
    logic [31:0] rsp_data;
    logic        rsp_data_valid;
    logic [29:0] rsp_inv_addr;
    logic        rsp_inv_valid;
    logic        rsp_inv_ack;
    logic        sc_complete;
    logic        sc_success;
    logic        ext_wr_valid;
    logic [31:0] ext_wr_addr;
    logic        ext_wr_ready;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [MemAw-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem   [MemWords];
    logic [31:0] model [MemWords];

    logic [31:0] exp_rd_addr[$];
    logic [31:0] exp_data[$];
    logic [49:0] exp_wr[$];
    logic        exp_sc[$];

    always #5 clk = ~clk;

    l1_mem_responder #(
        .LINE_W     (4),
        .MEM_ADDR_W (MemAw)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_request    (req_request),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_rnw        (req_rnw),
        .req_be         (req_be),
        .req_size       (req_size),
        .req_is_amo     (req_is_amo),
        .req_amo        (req_amo),
        .req_ack        (req_ack),
        .rsp_data       (rsp_data),
        .rsp_data_valid (rsp_data_valid),
        .rsp_inv_addr   (rsp_inv_addr),
        .rsp_inv_valid  (rsp_inv_valid),
        .rsp_inv_ack    (rsp_inv_ack),
        .sc_complete    (sc_complete),
        .sc_success     (sc_success),
        .ext_wr_valid   (ext_wr_valid),
        .ext_wr_addr    (ext_wr_addr),
        .ext_wr_ready   (ext_wr_ready),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every DUT output event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_data_valid) begin
                if (exp_data.size() == 0) check("unexpected_data_valid", 64'(rsp_data), 64'hx);
                else check("rsp_data", 64'(rsp_data), 64'(exp_data.pop_front()));
            end
            if (mem_en && !mem_we) begin
                if (exp_rd_addr.size() == 0) check("unexpected_mem_read", 64'(mem_addr), 64'hx);
                else check("mem_rd_addr", 64'(mem_addr), 64'(exp_rd_addr.pop_front()));
            end
            if (mem_en && mem_we) begin
                if (exp_wr.size() == 0) check("unexpected_mem_write", 64'(mem_addr), 64'hx);
                else check("mem_write", 64'({mem_addr, mem_be, mem_wdata}),
                           64'(exp_wr.pop_front()));
            end
            if (sc_complete) begin
                if (exp_sc.size() == 0) check("unexpected_sc_complete", 64'(sc_success), 64'hx);
                else check("sc_success", 64'(sc_success), 64'(exp_sc.pop_front()));
            end
        end
    end

    task automatic push_read(input logic [31:0] addr, input int size);
        int idx;
        int win;
        logic [31:0] base;
        idx = (size > 3) ? 3 : size;
        win = 1;
        while (win < idx + 1) win = win * 2;
        base = (addr >> 2) & ~(32'(win) - 32'd1);
        for (int i = 0; i <= idx; i++) begin
            exp_rd_addr.push_back(base + 32'(i));
            exp_data.push_back(model[base + 32'(i)]);
        end
    endtask

    task automatic push_write(input logic [31:0] word, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model[word][8*b +: 8] = d[8*b +: 8];
        end
        exp_wr.push_back({word[MemAw-1:0], be, d});
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic rnw,
                             input logic [3:0] be, input logic [4:0] sz, input logic amo_f,
                             input logic [4:0] op);
        req_addr    = a;
        req_data    = d;
        req_rnw     = rnw;
        req_be      = be;
        req_size    = sz;
        req_is_amo  = amo_f;
        req_amo     = op;
        req_request = 1'b1;
    endtask

    task automatic wait_ack(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ack) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
        @(posedge clk);
        #1 req_request = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check(tag, 64'(exp_rd_addr.size() + exp_data.size() + exp_wr.size() + exp_sc.size()),
              64'd0);
    endtask

    logic [5:0] beats;
    int         nbeats;

    initial begin
        rst = 1'b1;
        req_request = 1'b0; req_addr = '0; req_data = '0; req_rnw = 1'b0; req_be = '0;
        req_size = '0; req_is_amo = 1'b0; req_amo = '0;
        rsp_inv_ack = 1'b0; ext_wr_valid = 1'b0; ext_wr_addr = '0;
        for (int i = 0; i < int'(MemWords); i++) begin
            mem[i]   = 32'hA500_0000 | (32'(i) * 32'd3);
            model[i] = 32'hA500_0000 | (32'(i) * 32'd3);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_data_valid", 64'(rsp_data_valid), 64'd0);
        check("rst_inv_valid", 64'(rsp_inv_valid), 64'd0);
        check("rst_sc", 64'({sc_complete, sc_success}), 64'd0);
        check("rst_ext_ready", 64'(ext_wr_ready), 64'd0);
        check("rst_mem_en_we", 64'({mem_en, mem_we}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Aligned 4-word read from 0x108 covers words 0x40..0x43.
        push_read(32'h108, 3);
        drive_req(32'h108, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'd0);
        wait_ack("rd_ack");
        beats = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            beats = {beats[4:0], rsp_data_valid};
        end
        check("rd_beat_pattern", 64'(beats), 64'b011110);
        settle(2);
        check_drained("rd_drained");

        // Partial write.
        push_write(32'h8, 4'b0011, 32'hAABB_CCDD);
        drive_req(32'h20, 32'hAABB_CCDD, 1'b0, 4'b0011, 5'd0, 1'b0, 5'd0);
        wait_ack("wr_ack");
        settle(3);
        check("wr_mem_word", 64'(mem[8]), 64'(model[8]));
        check_drained("wr_drained");

        // LR then SC succeeds, second SC fails.
        push_read(32'h200, 0);
        drive_req(32'h200, 32'h0, 1'b1, 4'h0, 5'd0, 1'b1, 5'b00010);
        wait_ack("lr_ack");
        settle(4);
        exp_sc.push_back(1'b1);
        push_write(32'h80, 4'hF, 32'h1234_5678);
        drive_req(32'h200, 32'h1234_5678, 1'b0, 4'hF, 5'd0, 1'b1, 5'b00011);
        wait_ack("sc1_ack");
        settle(3);
        check("sc1_mem", 64'(mem[32'h80]), 64'h1234_5678);
        exp_sc.push_back(1'b0);
        drive_req(32'h200, 32'h0000_9999, 1'b0, 4'hF, 5'd0, 1'b1, 5'b00011);
        wait_ack("sc2_ack");
        settle(3);
        check("sc2_mem_kept", 64'(mem[32'h80]), 64'h1234_5678);
        check_drained("sc_drained");

        // A write to another address leaves the reservation alone.
        push_read(32'h200, 0);
        drive_req(32'h200, 32'h0, 1'b1, 4'h0, 5'd0, 1'b1, 5'b00010);
        wait_ack("lr2_ack");
        settle(4);
        push_write(32'h8, 4'hF, 32'h0102_0304);
        drive_req(32'h20, 32'h0102_0304, 1'b0, 4'hF, 5'd0, 1'b0, 5'd0);
        wait_ack("wr2_ack");
        settle(2);
        exp_sc.push_back(1'b1);
        push_write(32'h80, 4'hF, 32'h0000_55AA);
        drive_req(32'h200, 32'h0000_55AA, 1'b0, 4'hF, 5'd0, 1'b1, 5'b00011);
        wait_ack("sc3_ack");
        settle(3);
        check_drained("resv_keep_drained");

        // Snoop to the reserved address kills the reservation.
        push_read(32'h200, 0);
        drive_req(32'h200, 32'h0, 1'b1, 4'h0, 5'd0, 1'b1, 5'b00010);
        wait_ack("lr3_ack");
        settle(4);
        ext_wr_valid = 1'b1;
        ext_wr_addr  = 32'h200;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("inv_valid_hold", 64'(rsp_inv_valid), 64'd1);
            check("inv_addr_hold", 64'(rsp_inv_addr), 64'h80);
            check("inv_ready_low", 64'(ext_wr_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_inv_ack = 1'b1;
        @(negedge clk);
        check("inv_addr_at_ack", 64'(rsp_inv_addr), 64'h80);
        check("ext_ready_pulse", 64'(ext_wr_ready), 64'd1);
        @(posedge clk);
        #1 begin
            ext_wr_valid = 1'b0;
            rsp_inv_ack  = 1'b0;
        end
        @(negedge clk);
        check("inv_done_outputs", 64'({rsp_inv_valid, ext_wr_ready}), 64'd0);
        exp_sc.push_back(1'b0);
        drive_req(32'h200, 32'hDEAD_BEEF, 1'b0, 4'hF, 5'd0, 1'b1, 5'b00011);
        wait_ack("sc4_ack");
        settle(3);
        check("sc4_mem_kept", 64'(mem[32'h80]), 64'h0000_55AA);
        check_drained("snoop_drained");

        // Snoop and request together: request waits until the invalidate completes.
        push_read(32'h0, 1);
        drive_req(32'h0, 32'h0, 1'b1, 4'h0, 5'd1, 1'b0, 5'd0);
        ext_wr_valid = 1'b1;
        ext_wr_addr  = 32'h400;
        @(negedge clk);
        check("coll_no_ack_idle", 64'(req_ack), 64'd0);
        @(negedge clk);
        check("coll_no_ack_inv", 64'({rsp_inv_valid, req_ack}), 64'b10);
        @(posedge clk);
        #1 rsp_inv_ack = 1'b1;
        @(negedge clk);
        check("coll_no_ack_inv_done", 64'({ext_wr_ready, req_ack}), 64'b10);
        @(posedge clk);
        #1 begin
            ext_wr_valid = 1'b0;
            rsp_inv_ack  = 1'b0;
        end
        wait_ack("coll_req_served");
        settle(5);
        check_drained("coll_drained");

        // Oversized burst clamps to LINE_W words.
        push_read(32'h0, 31);
        drive_req(32'h0, 32'h0, 1'b1, 4'h0, 5'd31, 1'b0, 5'd0);
        wait_ack("clamp_ack");
        settle(8);
        check_drained("clamp_drained");

        // Non-LR/SC AMO is a plain read even with rnw low.
        push_read(32'h30, 0);
        drive_req(32'h30, 32'hFFFF_FFFF, 1'b0, 4'hF, 5'd0, 1'b1, 5'b00000);
        wait_ack("amo_ack");
        settle(4);
        check("amo_no_write", 64'(mem[32'hC]), 64'(model[32'hC]));
        check_drained("amo_drained");

        // Reset during the second data beat abandons the burst.
        exp_rd_addr.push_back(32'h40);
        exp_rd_addr.push_back(32'h41);
        exp_data.push_back(model[32'h40]);
        drive_req(32'h108, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'd0);
        wait_ack("rst_rd_ack");
        settle(2);
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        nbeats = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_data_valid) nbeats++;
        end
        check("rst_no_more_beats", 64'(nbeats), 64'd0);
        check_drained("rst_drained");
        settle(1);
        push_read(32'h108, 3);
        drive_req(32'h108, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'd0);
        wait_ack("post_rst_ack");
        settle(8);
        check_drained("post_rst_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
